// File: rtl/blkram_pkg.sv
// Shared types and helpers for blkram_sdp: clear FSM states, parameter legality, byte merge.
// Combinational only; no latency or backpressure of its own.
package blkram_pkg;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int MAX_DW     = 1024;

  function automatic bit params_ok(input int dw, input int rd_lat);
    return (dw > 0) && (dw % 8 == 0) && (dw < MAX_DW) &&
           (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
  endfunction

  // Callers zero-extend narrower words into MAX_DW and slice the result back.
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]   old_w,
                                                   input logic [MAX_DW-1:0]   new_w,
                                                   input logic [MAX_DW/8-1:0] be);
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_DW/8; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/blkram_clr_ctrl.sv
// Post-reset clear sequencer: sweeps every word once, then holds ST_READY until reset.
// One write per cycle for 2**AW cycles; no backpressure.
module blkram_clr_ctrl
  import blkram_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          init_busy,
  output logic          ready
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == {AW{1'b1}}) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_addr  = cnt_q;
  assign init_busy = (state_q == ST_CLEAR);
  assign ready     = (state_q == ST_READY);

endmodule

// File: rtl/blkram_sdp.sv
// Simple dual-port RAM, byte enables, RD_LAT (1|2) registered read, post-reset clear; no backpressure.
// `define BLKRAM_FWD_EN forwards a same-cycle same-address write into the read (default read-first).
module blkram_sdp
  import blkram_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 15,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW/8-1:0] wr_be,
  input  logic [DW-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            init_busy
);

  localparam int DEPTH = 2**AW;
  localparam int BW    = DW/8;

  if (!params_ok(DW, RD_LAT)) begin : g_param_err
    $error("blkram_sdp: DW must be a multiple of 8 and RD_LAT must be 1 or 2");
  end

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we, ready;
  logic [AW-1:0] clr_addr;

  blkram_clr_ctrl #(.AW(AW)) u_clr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy),
    .ready     (ready)
  );

  logic              wr_acc, rd_acc, mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdat, wr_merged, rd_word;
  logic [MAX_DW-1:0] old_x, new_x, merged_x;
  logic [MAX_DW/8-1:0] be_x;
  logic              unused_merge_hi;

  always_comb begin
    wr_acc = ready && wr_en;
    rd_acc = ready && rd_en;
    old_x  = '0;
    new_x  = '0;
    be_x   = '0;
    old_x[DW-1:0] = mem[wr_addr];
    new_x[DW-1:0] = wr_data;
    be_x[BW-1:0]  = wr_be;
    merged_x  = byte_merge(old_x, new_x, be_x);
    wr_merged = merged_x[DW-1:0];
    rd_word   = mem[rd_addr];
`ifdef BLKRAM_FWD_EN
    if (wr_acc && (wr_addr == rd_addr)) rd_word = wr_merged;
`endif
    // Clear and user writes never overlap: user writes are gated by ready.
    mem_we    = clr_we || wr_acc;
    mem_waddr = clr_we ? clr_addr : wr_addr;
    mem_wdat  = clr_we ? '0 : wr_merged;
  end

  assign unused_merge_hi = ^merged_x[MAX_DW-1:DW];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  logic          out_vld;
  logic [DW-1:0] out_dat;

  if (RD_LAT == 2) begin : g_lat2
    logic          s1_vld_q, s1_vld_d;
    logic [DW-1:0] s1_dat_q, s1_dat_d;

    always_comb begin
      s1_vld_d = rd_acc;
      s1_dat_d = rd_acc ? rd_word : s1_dat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld_q <= 1'b0;
        s1_dat_q <= '0;
      end else begin
        s1_vld_q <= s1_vld_d;
        s1_dat_q <= s1_dat_d;
      end
    end

    assign out_vld = s1_vld_q;
    assign out_dat = s1_dat_q;
  end else begin : g_lat1
    assign out_vld = rd_acc;
    assign out_dat = rd_word;
  end

  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_valid_d = out_vld;
    rd_data_d  = out_vld ? out_dat : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
